// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler
// Gives one requesting unit at a time the single memory port, choosing units
// round-robin. The owner's address, write data and strobes are passed through
// to memory. Read data comes back registered and tagged with the unit that
// issued the read. An owner is forced off the port after MAX_BURST accesses.
// A one-cycle release bubble separates two owners, so a unit that has just
// lost the port cannot drive a stray access.

module mem_access_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int WORD_SIZE       = 32,
    parameter int BLOCK_SIZE      = 3,
    parameter int LOG_MEMORY_SIZE = 10,
    parameter int MAX_BURST       = 4
) (
    input  logic                                          in_clk,
    input  logic                                          in_reset,
    input  logic [NUM_REQ-1:0]                            in_req,
    input  logic [NUM_REQ-1:0]                            in_last,
    input  logic [NUM_REQ-1:0]                            in_we,
    input  logic [NUM_REQ-1:0]                            in_re,
    input  logic [NUM_REQ*LOG_MEMORY_SIZE-1:0]            in_addr,
    input  logic [NUM_REQ*WORD_SIZE*BLOCK_SIZE-1:0]       in_wdata,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0]               in_mem_rdata,
    output logic [NUM_REQ-1:0]                            out_grant,
    output logic [LOG_MEMORY_SIZE-1:0]                    out_mem_addr,
    output logic [WORD_SIZE*BLOCK_SIZE-1:0]               out_mem_wdata,
    output logic                                          out_mem_we,
    output logic                                          out_mem_re,
    output logic [WORD_SIZE*BLOCK_SIZE-1:0]               out_rdata,
    output logic [NUM_REQ-1:0]                            out_rvalid,
    output logic                                          out_busy
);

    localparam int LINE_W = WORD_SIZE * BLOCK_SIZE;
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_burst;
    logic [NUM_REQ-1:0]   r_rd_tag;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic [LINE_W-1:0]    r_rdata;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic                 w_pick_found;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_own_req;
    logic                 w_own_we;
    logic                 w_own_re;
    logic                 w_own_last;
    logic [NUM_REQ-1:0]   w_own_onehot;
    logic                 w_in_grant;
    logic                 w_access;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_burst_full;
    logic                 w_exit;

    // Rotate the request vector so bit 0 is the unit the pointer favours
    assign w_req_dbl = {in_req, in_req};
    assign w_req_rot = w_req_rot_f(w_req_dbl, r_ptr);

    function automatic logic [NUM_REQ-1:0] w_req_rot_f(input logic [2*NUM_REQ-1:0] dbl,
                                                       input logic [PTR_W-1:0] sh);
        logic [2*NUM_REQ-1:0] tmp;
        tmp = dbl >> sh;
        return tmp[NUM_REQ-1:0];
    endfunction

    // Round-robin pick: first requesting unit at or above the pointer, with wrap
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_pick_found && w_req_rot[k]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            end else begin
                w_pick_found = w_pick_found;
            end
        end
    end

    // Owner's request-side controls
    assign w_own_req    = in_req[r_owner];
    assign w_own_we     = in_we[r_owner];
    assign w_own_re     = in_re[r_owner];
    assign w_own_last   = in_last[r_owner];
    assign w_own_onehot = ONE_HOT_0 << r_owner;

    // Accesses count only while the owner still holds its request
    assign w_in_grant   = (r_state == ST_GRANT);
    assign w_access     = w_in_grant & w_own_req & (w_own_we | w_own_re);
    assign w_wr         = w_access & w_own_we;
    assign w_rd         = w_access & w_own_re & ~w_own_we;
    assign w_burst_full = (r_burst == CNT_W'(MAX_BURST - 1));
    assign w_exit       = w_in_grant & (~w_own_req | (w_access & (w_own_last | w_burst_full)));

    // Memory address/data follow the owner during GRANT and are zero otherwise
    always_comb begin
        out_mem_addr  = {LOG_MEMORY_SIZE{1'b0}};
        out_mem_wdata = {LINE_W{1'b0}};
        if (w_in_grant) begin
            out_mem_addr  = in_addr[r_owner*LOG_MEMORY_SIZE +: LOG_MEMORY_SIZE];
            out_mem_wdata = in_wdata[r_owner*LINE_W +: LINE_W];
        end else begin
            out_mem_addr  = {LOG_MEMORY_SIZE{1'b0}};
            out_mem_wdata = {LINE_W{1'b0}};
        end
    end

    assign out_mem_we = w_wr;
    assign out_mem_re = w_rd;
    assign out_grant  = r_grant;
    assign out_rdata  = r_rdata;
    assign out_rvalid = r_rvalid;
    assign out_busy   = (r_state == ST_GRANT) || (r_state == ST_RELEASE);

    // Grant FSM: pick in IDLE, count accesses in GRANT, advance pointer in RELEASE
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= ST_IDLE;
            r_grant <= {NUM_REQ{1'b0}};
            r_owner <= {PTR_W{1'b0}};
            r_ptr   <= {PTR_W{1'b0}};
            r_burst <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_grant <= ONE_HOT_0 << w_pick_idx;
                        r_owner <= w_pick_idx;
                        r_burst <= {CNT_W{1'b0}};
                        r_state <= ST_GRANT;
                    end else begin
                        r_grant <= {NUM_REQ{1'b0}};
                    end
                end
                ST_GRANT: begin
                    if (w_access) begin
                        r_burst <= r_burst + CNT_W'(1);
                    end else begin
                        r_burst <= r_burst;
                    end
                    if (w_exit) begin
                        r_grant <= {NUM_REQ{1'b0}};
                        r_state <= ST_RELEASE;
                    end else begin
                        r_state <= ST_GRANT;
                    end
                end
                ST_RELEASE: begin
                    if (r_owner == PTR_W'(NUM_REQ - 1)) begin
                        r_ptr <= {PTR_W{1'b0}};
                    end else begin
                        r_ptr <= r_owner + PTR_W'(1);
                    end
                    r_burst <= {CNT_W{1'b0}};
                    r_grant <= {NUM_REQ{1'b0}};
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_grant <= {NUM_REQ{1'b0}};
                    r_burst <= {CNT_W{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read return: remember the issuing unit, then capture memory data a cycle later
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_rd_tag <= {NUM_REQ{1'b0}};
            r_rvalid <= {NUM_REQ{1'b0}};
            r_rdata  <= {LINE_W{1'b0}};
        end else begin
            if (w_rd) begin
                r_rd_tag <= w_own_onehot;
            end else begin
                r_rd_tag <= {NUM_REQ{1'b0}};
            end
            r_rvalid <= r_rd_tag;
            if (|r_rd_tag) begin
                r_rdata <= in_mem_rdata;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

endmodule
